// File: rtl/det_4x4_sched.sv
// Round-robin share of one det_4x4 unit between two requesters; result DET_LATENCY+1 edges after accept.
// Backpressure: no new accept while a job is in WAIT or a result waits in RESP for res_ready.
module det_4x4_sched #(
   parameter int DET_LATENCY = 1,
   parameter int CNT_W       = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   input  logic [127:0] req0_A,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic [127:0] req1_A,
   output logic         req1_ready,
   output logic [127:0] det_A,
   input  logic [7:0]   det_in,
   input  logic         ovf_in,
   output logic         res_valid,
   input  logic         res_ready,
   output logic [7:0]   res_det,
   output logic         res_ovf,
   output logic         res_id,
   output logic         busy,
   output logic [7:0]   ovf_count
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               last_grant;
   logic               grant;
   logic               accept;

   // Contention alternates away from the previous winner.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid)
         grant = ~last_grant;
      else if (req1_valid)
         grant = 1'b1;
   end

   // Gated by rst so no requester sees an accept while reset is held.
   assign req0_ready = ~rst && (state == IDLE) && !grant && req0_valid;
   assign req1_ready = ~rst && (state == IDLE) &&  grant && req1_valid;
   assign accept     = req0_ready || req1_ready;
   assign busy       = (state != IDLE);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         det_A      <= '0;
         res_det    <= '0;
         res_ovf    <= 1'b0;
         res_id     <= 1'b0;
         res_valid  <= 1'b0;
         cnt        <= '0;
         last_grant <= 1'b1;
         ovf_count  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  det_A      <= grant ? req1_A : req0_A;
                  res_id     <= grant;
                  last_grant <= grant;
                  cnt        <= CNT_W'(DET_LATENCY);
                  state      <= WAIT;
               end
            end
            WAIT: begin
               if (cnt != '0) begin
                  cnt <= cnt - CNT_W'(1);
               end else begin
                  res_det   <= det_in;
                  res_ovf   <= ovf_in;
                  res_valid <= 1'b1;
                  state     <= RESP;
               end
            end
            RESP: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  state     <= IDLE;
                  if (res_ovf && (ovf_count != 8'hFF))
                     ovf_count <= ovf_count + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_det_4x4_sched.sv
// Bench for det_4x4_sched: latency-1 instance with a det_4x4 stand-in and scoreboard, latency-3 instance for timing and saturation.
module tb_det_4x4_sched;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic longint det4(input logic [127:0] m);
      longint a[4][4];
      longint mm[3][3];
      longint s, d3;
      int k;
      logic signed [7:0] v;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) begin
            v = m[(15 - (r*4 + c))*8 +: 8];
            a[r][c] = longint'(v);
         end
      s = 0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 1; r < 4; r++) begin
            k = 0;
            for (int cc = 0; cc < 4; cc++)
               if (cc != c) begin
                  mm[r-1][k] = a[r][cc];
                  k++;
               end
         end
         d3 = mm[0][0]*(mm[1][1]*mm[2][2] - mm[1][2]*mm[2][1])
            - mm[0][1]*(mm[1][0]*mm[2][2] - mm[1][2]*mm[2][0])
            + mm[0][2]*(mm[1][0]*mm[2][1] - mm[1][1]*mm[2][0]);
         s += (((c % 2) == 0) ? 64'sd1 : -64'sd1) * a[0][c] * d3;
      end
      return s;
   endfunction

   function automatic logic [7:0] lo8(input longint v);
      return v[7:0];
   endfunction

   function automatic logic ovf8(input longint v);
      return (v > 127) || (v < -128);
   endfunction

   function automatic logic [127:0] diag(input int p, input int q, input int r, input int s);
      logic [127:0] m;
      m = '0;
      m[127:120] = 8'(p);
      m[87:80]   = 8'(q);
      m[47:40]   = 8'(r);
      m[7:0]     = 8'(s);
      return m;
   endfunction

   // ---------------- instance a: DET_LATENCY = 1 ----------------
   logic         rst = 1'b1;
   logic         req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b1;
   logic [127:0] req0_A = '0, req1_A = '0;
   logic         req0_ready, req1_ready, res_valid, res_ovf, res_id, busy, ovf_in;
   logic [127:0] det_A;
   logic [7:0]   det_in, res_det, ovf_count;

   det_4x4_sched #(.DET_LATENCY(1), .CNT_W(4)) u_a (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_A(req0_A), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_A(req1_A), .req1_ready(req1_ready),
      .det_A(det_A), .det_in(det_in), .ovf_in(ovf_in),
      .res_valid(res_valid), .res_ready(res_ready), .res_det(res_det),
      .res_ovf(res_ovf), .res_id(res_id), .busy(busy), .ovf_count(ovf_count)
   );

   // One-stage det_4x4 stand-in.
   always_ff @(posedge clk) begin
      det_in <= lo8(det4(det_A));
      ovf_in <= ovf8(det4(det_A));
   end

   // ---------------- instance b: DET_LATENCY = 3 ----------------
   logic         b_req0_valid = 1'b0, b_req1_valid = 1'b0, b_res_ready = 1'b1, force_ovf = 1'b0;
   logic [127:0] b_req0_A = '0, b_req1_A = '0;
   logic         b_req0_ready, b_req1_ready, b_res_valid, b_res_ovf, b_res_id, b_busy, b_ovf_in;
   logic [127:0] b_det_A;
   logic [7:0]   b_det_in, b_res_det, b_ovf_count;
   logic [7:0]   b_pd[3];
   logic         b_po[3];

   det_4x4_sched #(.DET_LATENCY(3), .CNT_W(4)) u_b (
      .clk(clk), .rst(rst),
      .req0_valid(b_req0_valid), .req0_A(b_req0_A), .req0_ready(b_req0_ready),
      .req1_valid(b_req1_valid), .req1_A(b_req1_A), .req1_ready(b_req1_ready),
      .det_A(b_det_A), .det_in(b_det_in), .ovf_in(b_ovf_in),
      .res_valid(b_res_valid), .res_ready(b_res_ready), .res_det(b_res_det),
      .res_ovf(b_res_ovf), .res_id(b_res_id), .busy(b_busy), .ovf_count(b_ovf_count)
   );

   always_ff @(posedge clk) begin
      b_pd[0] <= lo8(det4(b_det_A));
      b_po[0] <= ovf8(det4(b_det_A));
      b_pd[1] <= b_pd[0];
      b_po[1] <= b_po[0];
      b_pd[2] <= b_pd[1];
      b_po[2] <= b_po[1];
   end
   assign b_det_in = b_pd[2];
   assign b_ovf_in = b_po[2] | force_ovf;

   // ---------------- scoreboard for instance a ----------------
   typedef struct packed {
      logic [7:0] det;
      logic       ovf;
      logic       id;
   } exp_t;
   exp_t sbq[$];
   exp_t got_e, exp_e;

   always @(negedge clk) begin
      if (rst) begin
         sbq.delete();
      end else begin
         if (req0_ready || req1_ready)
            check("ready_onehot", 128'(req0_ready & req1_ready), 128'(0));
         if (req0_ready)
            sbq.push_back('{det: lo8(det4(req0_A)), ovf: ovf8(det4(req0_A)), id: 1'b0});
         if (req1_ready)
            sbq.push_back('{det: lo8(det4(req1_A)), ovf: ovf8(det4(req1_A)), id: 1'b1});
         if (res_valid && res_ready) begin
            check("sb_nonempty", 128'(sbq.size() != 0), 128'(1));
            if (sbq.size() != 0) begin
               exp_e = sbq.pop_front();
               got_e = '{det: res_det, ovf: res_ovf, id: res_id};
               check("sb_result", 128'(got_e), 128'(exp_e));
            end
         end
      end
   end

   // ---------------- helpers ----------------
   // Presents one matrix on the chosen port of instance a and waits out the result.
   task automatic run_a(input logic [127:0] m, input logic port, output int lat,
                        output logic [7:0] d, output logic o, output logic id);
      bit got;
      @(posedge clk); #1;
      if (port) begin req1_A = m; req1_valid = 1'b1; end
      else      begin req0_A = m; req0_valid = 1'b1; end
      got = 0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         got = port ? req1_ready : req0_ready;
      end
      check("accept_seen", 128'(got), 128'(1));
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      lat = 0;
      got = 0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (res_valid) got = 1;
         else begin @(posedge clk); lat++; end
      end
      check("result_seen", 128'(got), 128'(1));
      d  = res_det;
      o  = res_ovf;
      id = res_id;
      @(posedge clk); #1;
   endtask

   task automatic drain_a();
      bit done;
      done = 0;
      for (int i = 0; i < 60 && !done; i++) begin
         @(negedge clk);
         done = !busy && !res_valid;
      end
      check("drain_a", 128'(done), 128'(1));
   endtask

   typedef struct {
      logic [127:0] a;
      logic         port;
      logic [7:0]   det;
      logic         ovf;
   } vec_t;
   vec_t vecs[9];

   logic [127:0] m_ident, m_dep, m_ovf, m_swap;
   int           lat, exp_ovfc, k, ids[6], dets[6];
   logic [7:0]   d, d0;
   logic         o, id, pend;
   bit           ok;

   initial begin
      m_ident = diag(1, 1, 1, 1);
      m_dep   = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8,
                 8'd1, 8'd2, 8'd3, 8'd4, 8'd9, 8'd10, 8'd11, 8'd12};
      m_ovf   = {8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80,
                 8'd90, 8'h9C, 8'h92, 8'h88, 8'd100, 8'd110, 8'd120, 8'd127};
      m_swap  = {8'd0, 8'd1, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0,
                 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
      vecs[0] = '{m_ident,            1'b0, 8'h01, 1'b0};
      vecs[1] = '{m_dep,              1'b0, 8'h00, 1'b0};
      vecs[2] = '{m_ovf,              1'b1, 8'hC0, 1'b1};  // 216000 wraps to -64
      vecs[3] = '{diag(2, 3, 4, 5),   1'b1, 8'h78, 1'b0};
      vecs[4] = '{diag(2, 3, 4, 6),   1'b0, 8'h90, 1'b1};
      vecs[5] = '{diag(-2, 4, 4, 4),  1'b1, 8'h80, 1'b0};
      vecs[6] = '{diag(4, 4, 4, 2),   1'b0, 8'h80, 1'b1};
      vecs[7] = '{m_swap,             1'b1, 8'hFF, 1'b0};
      vecs[8] = '{diag(127, 1, 1, 1), 1'b1, 8'h7F, 1'b0};

      // Reset state, with requesters already asserting valid.
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_req0_ready", 128'(req0_ready), 128'(0));
      check("rst_req1_ready", 128'(req1_ready), 128'(0));
      check("rst_res_valid",  128'(res_valid), 128'(0));
      check("rst_busy",       128'(busy), 128'(0));
      check("rst_det_A",      det_A, 128'(0));
      check("rst_res",        128'({res_det, res_ovf, res_id}), 128'(0));
      check("rst_ovf_count",  128'(ovf_count), 128'(0));
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(posedge clk); #1 rst = 1'b0;

      // Identity on req0: two edges from accept to res_valid.
      run_a(m_ident, 1'b0, lat, d, o, id);
      check("ident_latency", 128'(lat), 128'(2));
      check("ident_result",  128'({d, o, id}), 128'({8'h01, 1'b0, 1'b0}));
      check("ident_busy_low", 128'(busy), 128'(0));

      exp_ovfc = 0;
      foreach (vecs[i]) begin
         run_a(vecs[i].a, vecs[i].port, lat, d, o, id);
         if (vecs[i].ovf) exp_ovfc++;
         check($sformatf("vec%0d_det", i), 128'(d),  128'(vecs[i].det));
         check($sformatf("vec%0d_ovf", i), 128'(o),  128'(vecs[i].ovf));
         check($sformatf("vec%0d_id", i),  128'(id), 128'(vecs[i].port));
         @(negedge clk);
         check($sformatf("vec%0d_ovf_count", i), 128'(ovf_count), 128'(exp_ovfc));
      end

      // Both requesters continuously valid: strict alternation starting with req0.
      @(posedge clk); #1;
      req0_A = m_dep;  req1_A = m_ident;
      req0_valid = 1'b1; req1_valid = 1'b1;
      k = 0;
      for (int i = 0; i < 300 && k < 6; i++) begin
         @(negedge clk);
         if (res_valid && res_ready) begin
            ids[k]  = int'(res_id);
            dets[k] = int'(res_det);
            k++;
         end
      end
      check("alt_count", 128'(k), 128'(6));
      for (int i = 0; i < 6; i++) begin
         check($sformatf("alt_id%0d", i),  128'(ids[i]),  128'(i % 2));
         check($sformatf("alt_det%0d", i), 128'(dets[i]), 128'(i % 2));
      end
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      drain_a();

      // Result backpressure: everything frozen, no readys, accept resumes next cycle.
      @(posedge clk); #1;
      res_ready = 1'b0;
      req0_A = m_ident; req0_valid = 1'b1;
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = res_valid; end
      check("bp_result_seen", 128'(ok), 128'(1));
      req1_A = diag(2, 3, 4, 5);
      req1_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_hold", 128'({res_valid, res_det, res_id, req0_ready, req1_ready, busy}),
               128'({1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1}));
      end
      @(posedge clk); #1 res_ready = 1'b1;
      @(negedge clk);
      check("bp_no_ready_in_resp", 128'({req0_ready, req1_ready}), 128'(0));
      @(negedge clk);
      check("bp_resume_req1", 128'({req0_ready, req1_ready}), 128'(2'b01));
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      drain_a();

      // Reset mid-WAIT discards the req0 job and restores last_grant.
      @(posedge clk); #1;
      req0_A = m_ident; req0_valid = 1'b1;
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = req0_ready; end
      check("rst_test_accept", 128'(ok), 128'(1));
      @(posedge clk); #1 req1_valid = 1'b1;
      @(negedge clk);
      check("rst_test_in_wait", 128'(busy), 128'(1));
      rst = 1'b1;
      #1;
      check("midrst_outputs", 128'({busy, res_valid, req0_ready, req1_ready, res_id, res_ovf, res_det}), 128'(0));
      check("midrst_det_A", det_A, 128'(0));
      check("midrst_ovf_count", 128'(ovf_count), 128'(0));
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("midrst_no_result", 128'(res_valid), 128'(0));
      end
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("post_rst_grant0", 128'({req0_ready, req1_ready}), 128'(2'b10));
      @(posedge clk); #1;
      req0_valid = 1'b0; req1_valid = 1'b0;
      drain_a();

      // Instance b: DET_LATENCY=3 identity, then ovf_count saturation.
      @(posedge clk); #1;
      b_req0_A = m_ident; b_req0_valid = 1'b1;
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin @(negedge clk); ok = b_req0_ready; end
      check("b_accept", 128'(ok), 128'(1));
      @(posedge clk); #1 b_req0_valid = 1'b0;
      lat = 0; ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         if (b_res_valid) ok = 1;
         else begin @(posedge clk); lat++; end
      end
      check("b_latency", 128'(lat), 128'(4));
      check("b_result", 128'({b_res_det, b_res_ovf, b_res_id}), 128'({8'h01, 1'b0, 1'b0}));
      @(posedge clk); #1;
      force_ovf = 1'b1;
      b_req0_valid = 1'b1;
      k = 0; pend = 1'b0;
      for (int i = 0; i < 3000 && k < 258; i++) begin
         @(negedge clk);
         if (pend) begin
            k++;
            if (k == 1)   check("b_ovfc_1",   128'(b_ovf_count), 128'(1));
            if (k == 254) check("b_ovfc_254", 128'(b_ovf_count), 128'(254));
            if (k == 255) check("b_ovfc_255", 128'(b_ovf_count), 128'(255));
            if (k == 258) check("b_ovfc_sat", 128'(b_ovf_count), 128'(255));
         end
         pend = b_res_valid & b_res_ready;
      end
      check("b_sat_done", 128'(k), 128'(258));
      b_req0_valid = 1'b0;
      force_ovf = 1'b0;

      check("sb_empty_end", 128'(sbq.size()), 128'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
